// File: rtl/countdown_timer.sv
// Programmable N-bit down-counting timer with one-shot/periodic modes and a sticky interrupt flag.
// Define PRESCALER_EN to add the presc_div input and a tick prescaler (tick every presc_div+1 clocks).
module countdown_timer #(
    parameter int N       = 32,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [N-1:0]       load_value,
    input  logic               start,
    input  logic               stop,
    input  logic               periodic,
    input  logic               irq_ack,
`ifdef PRESCALER_EN
    input  logic [PRESC_W-1:0] presc_div,
`endif
    output logic [N-1:0]       count,
    output logic               running,
    output logic               expired,
    output logic               irq_pending,
    output logic               overrun
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       r_state;
    logic [N-1:0] r_count;
    logic [N-1:0] r_reload;
    logic         r_expired;
    logic         r_irq;
    logic         r_ovr;

    logic         w_in_run;
    logic         w_tick;
    logic         w_expire;
    logic         w_reload_ok;

    assign w_in_run = (r_state == S_RUN);

`ifdef PRESCALER_EN
    logic [PRESC_W-1:0] r_presc;

    assign w_tick = (r_presc == presc_div);

    // Held at zero outside RUN, so an accepted start always begins a full prescale period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (load || !w_in_run || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // Expiry only on a real decrement step: load and stop both pre-empt it.
    assign w_expire    = w_in_run && !load && !stop && w_tick && (r_count == CNT_ONE);
    assign w_reload_ok = periodic && (r_reload != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= w_expire;
            if (load) begin
                r_reload <= load_value;
                r_count  <= load_value;
            end else if (stop) begin
                if (w_in_run) begin
                    r_state <= S_IDLE;
                end
            end else if (start && !w_in_run) begin
                if (r_count != '0) begin
                    r_state <= S_RUN;
                end
            end else if (w_in_run && w_tick) begin
                if (r_count > CNT_ONE) begin
                    r_count <= r_count - CNT_ONE;
                end else if (r_count == CNT_ONE) begin
                    if (w_reload_ok) begin
                        r_count <= r_reload;
                    end else begin
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end
                end else begin
                    // A zero loaded while running has nothing left to count.
                    r_state <= S_IDLE;
                end
            end
        end
    end

    // irq_pending is a level request held until irq_ack; a new expiry beats a same-cycle ack,
    // and an expiry landing on an unacknowledged request is recorded as overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            r_irq <= w_expire | (r_irq & ~irq_ack);
            r_ovr <= (w_expire & r_irq & ~irq_ack) | (r_ovr & ~irq_ack);
        end
    end

    assign count       = r_count;
    assign running     = w_in_run;
    assign expired     = r_expired;
    assign irq_pending = r_irq;
    assign overrun     = r_ovr;

endmodule
